// File: rtl/alarm_buzzer_ctl.sv
// Alarm buzzer controller: qualifies the alarm match with Alarmon and drives a beeping buzzer
// with snooze (limited per event) and auto-silence; clocked by the 1 Hz pulse.
`timescale 1ns/1ps
module alarm_buzzer_ctl #(
  parameter int RING_MAX   = 60,
  parameter int SNOOZE_LEN = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              alarm_on,
  input  logic                              buzz_req,
  input  logic                              snooze,
  output logic                              buzz,
  output logic                              ringing,
  output logic [$clog2(MAX_SNOOZE+1)-1:0]   snooze_count
);

  localparam int RW = $clog2(RING_MAX);
  localparam int SW = $clog2(SNOOZE_LEN);
  localparam int CW = $clog2(MAX_SNOOZE+1);

  localparam logic [RW-1:0] RING_LAST = RW'(RING_MAX-1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_LEN-1);
  localparam logic [CW-1:0] SNZ_LIMIT = CW'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RING,
    ST_SNOOZE,
    ST_SILENCED
  } state_t;

  state_t          state;
  logic            req_d;
  logic            snz_d;
  logic [RW-1:0]   ring_ct;
  logic [SW-1:0]   snz_ct;

  logic req_rise;
  logic snz_rise;

  assign req_rise = buzz_req & ~req_d;
  assign snz_rise = snooze & ~snz_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      req_d        <= 1'b0;
      snz_d        <= 1'b0;
      ring_ct      <= '0;
      snz_ct       <= '0;
      snooze_count <= '0;
    end else begin
      req_d <= buzz_req;
      snz_d <= snooze;
      // Alarmon off cancels the event outright, whatever else happens this cycle.
      if (!alarm_on) begin
        state        <= ST_IDLE;
        ring_ct      <= '0;
        snz_ct       <= '0;
        snooze_count <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (req_rise) begin
              state   <= ST_RING;
              ring_ct <= '0;
            end
          end
          ST_RING: begin
            // Snooze beats timeout when both land on the last ring cycle.
            if (snz_rise && (snooze_count < SNZ_LIMIT)) begin
              state        <= ST_SNOOZE;
              snz_ct       <= '0;
              snooze_count <= snooze_count + 1'b1;
            end else if (ring_ct == RING_LAST) begin
              state <= ST_SILENCED;
            end else begin
              ring_ct <= ring_ct + 1'b1;
            end
          end
          ST_SNOOZE: begin
            // Event is latched: expiry re-rings even if buzz_req has since dropped.
            if (snz_ct == SNZ_LAST) begin
              state   <= ST_RING;
              ring_ct <= '0;
            end else begin
              snz_ct <= snz_ct + 1'b1;
            end
          end
          ST_SILENCED: begin
            if (!buzz_req) begin
              state        <= ST_IDLE;
              snooze_count <= '0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign buzz    = (state == ST_RING) & ~ring_ct[0];
  assign ringing = (state == ST_RING) | (state == ST_SNOOZE);

endmodule

// File: tb/tb_alarm_buzzer_ctl.sv
// Bench for alarm_buzzer_ctl (RING_MAX=6, SNOOZE_LEN=4, MAX_SNOOZE=2): vector table plus
// hand sequences for async reset; expectations queued at drive time, compared after each edge.
`timescale 1ns/1ps
module tb_alarm_buzzer_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alarm_on = 1'b0;
  logic       buzz_req = 1'b0;
  logic       snooze = 1'b0;
  logic       buzz;
  logic       ringing;
  logic [1:0] snooze_count;

  alarm_buzzer_ctl #(
    .RING_MAX   (6),
    .SNOOZE_LEN (4),
    .MAX_SNOOZE (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alarm_on     (alarm_on),
    .buzz_req     (buzz_req),
    .snooze       (snooze),
    .buzz         (buzz),
    .ringing      (ringing),
    .snooze_count (snooze_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       a;
    logic       r;
    logic       s;
    logic       eb;
    logic       eg;
    logic [1:0] ec;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic add(input logic a, input logic r, input logic s,
                     input logic eb, input logic eg, input logic [1:0] ec);
    vec_t v;
    v.a = a; v.r = r; v.s = s; v.eb = eb; v.eg = eg; v.ec = ec;
    vecs.push_back(v);
  endtask

  task automatic compare(input string name);
    logic [3:0] e;
    logic [3:0] act;
    act = {buzz, ringing, snooze_count};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no expectation queued, got buzz=%b ringing=%b count=%0d",
               name, buzz, ringing, snooze_count);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s: got buzz=%b ringing=%b count=%0d, expected buzz=%b ringing=%b count=%0d",
                 name, act[3], act[2], act[1:0], e[3], e[2], e[1:0]);
      end
    end
  endtask

  // One clock: drive inputs on the falling edge, check outputs just after the rising edge.
  task automatic step(input string name, input logic rv, input logic a, input logic r,
                      input logic s, input logic eb, input logic eg, input logic [1:0] ec);
    @(negedge clk);
    rst      = rv;
    alarm_on = a;
    buzz_req = r;
    snooze   = s;
    exp_q.push_back({eb, eg, ec});
    @(posedge clk);
    #1;
    compare(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected under 200000", $time);
    $fatal(1);
  end

  initial begin
    // basic ring: rise, 6-cycle beep pattern, silenced, no retrigger while held
    repeat (4) add(1,0,0, 0,0,0);
    add(1,1,0, 1,1,0); add(1,1,0, 0,1,0); add(1,1,0, 1,1,0);
    add(1,1,0, 0,1,0); add(1,1,0, 1,1,0); add(1,1,0, 0,1,0);
    repeat (4) add(1,1,0, 0,0,0);
    add(1,0,0, 0,0,0);
    // snooze, held button gives one event, expiry re-rings after buzz_req drops, limit
    add(1,1,0, 1,1,0); add(1,1,0, 0,1,0);
    repeat (4) add(1,1,1, 0,1,1);
    add(1,1,1, 1,1,1); add(1,1,1, 0,1,1); add(1,1,0, 1,1,1);
    add(1,1,1, 0,1,2);
    repeat (3) add(1,0,0, 0,1,2);
    add(1,0,0, 1,1,2); add(1,0,1, 0,1,2); add(1,0,0, 1,1,2);
    add(1,0,0, 0,1,2); add(1,0,0, 1,1,2); add(1,0,0, 0,1,2);
    add(1,0,0, 0,0,2); add(1,0,0, 0,0,0);
    // snooze on last ring cycle wins over timeout
    add(1,1,0, 1,1,0); add(1,1,0, 0,1,0); add(1,1,0, 1,1,0);
    add(1,1,0, 0,1,0); add(1,1,0, 1,1,0); add(1,1,0, 0,1,0);
    add(1,1,1, 0,1,1);
    // cancel during snooze; req rise with alarm off does not ring
    add(1,1,0, 0,1,1); add(0,1,0, 0,0,0); add(0,0,0, 0,0,0);
    add(0,1,0, 0,0,0); add(1,1,0, 0,0,0); add(1,0,0, 0,0,0);
    // cancel during ring
    add(1,1,0, 1,1,0); add(0,1,0, 0,0,0); add(1,1,0, 0,0,0); add(1,0,0, 0,0,0);

    // reset state
    #2;
    exp_q.push_back(4'b0000);
    compare("reset");

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), 1'b1, vecs[i].a, vecs[i].r, vecs[i].s,
           vecs[i].eb, vecs[i].eg, vecs[i].ec);
    end

    // async reset mid-RING while buzz is high
    step("rst_ring0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
    step("rst_ring1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    step("rst_ring2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
    #2;
    rst = 1'b0;
    #1;
    exp_q.push_back(4'b0000);
    compare("rst_async");
    step("rst_held", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    // release with buzz_req and alarm_on high: first edge sees a rise
    step("rst_rel0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
    step("rst_rel1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    step("rst_rel2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_buzzer_ctl.md
# alarm_buzzer_ctl

Consumer side of the alarm match signal: takes the level-style buzz request produced by the alarm comparator, qualifies it with the Alarmon switch, and drives the user-facing buzzer with a beep pattern, snooze handling and automatic timeout. It sits between the alarm compare block and the physical buzzer pin in the digital-clock top level. It is clocked by the 1 Hz Pulse clock, one cycle per second.

## Interface
- RING_MAX, 60: ring duration in cycles before auto-silence (≥2)
- SNOOZE_LEN, 300: snooze duration in cycles (≥2)
- MAX_SNOOZE, 3: snoozes allowed per alarm event (≥1)

- clk  input  1  clock (Pulse, 1 cycle/sec)
- rst  input  1  reset, asynchronous, active-low
- alarm_on  input  1  Alarmon switch level; low cancels everything
- buzz_req  input  1  alarm compare output, high while time == alarm time
- snooze  input  1  snooze button level, already debounced
- buzz  output  1  buzzer drive
- ringing  output  1  high in RING or SNOOZE, i.e. an alarm event is active
- snooze_count  output  $clog2(MAX_SNOOZE+1)  snoozes used in the current event

## Operation
- Registers: state (IDLE, RING, SNOOZE, SILENCED), req_d, snz_d, ring_ct ($clog2(RING_MAX) bits), snz_ct ($clog2(SNOOZE_LEN) bits), snooze_count.
- Edges: req_rise = buzz_req & ~req_d; snz_rise = snooze & ~snz_d. req_d and snz_d sample their inputs every cycle.
- Global override: alarm_on == 0 in any state forces next state IDLE, clears ring_ct, snz_ct and snooze_count. It has priority over all other events.
- IDLE: if alarm_on & req_rise, go to RING with ring_ct = 0. Otherwise stay.
- RING: ring_ct increments each cycle.
  - If snz_rise & snooze_count < MAX_SNOOZE, go to SNOOZE, snz_ct = 0, snooze_count += 1.
  - Else if ring_ct == RING_MAX-1, go to SILENCED.
  - A snooze press has priority over timeout in the same cycle.
  - A snz_rise when snooze_count == MAX_SNOOZE is ignored; ringing continues.
- SNOOZE: snz_ct increments. When snz_ct == SNOOZE_LEN-1, go to RING with ring_ct = 0. snz_rise is ignored.
- SILENCED: when buzz_req == 0, go to IDLE and clear snooze_count. snz_rise is ignored.
- Snooze expiry re-rings even if buzz_req has dropped, because the event is latched.
- buzz = (state == RING) & ~ring_ct[0]. This gives a beep on even counts and silence on odd counts. It is decoded only from registers, so it is glitch-free relative to inputs.
- ringing = (state == RING) | (state == SNOOZE).
- Counters never wrap. Each counter is reloaded on every state entry that uses it.

## Timing
- Reset (rst low, asynchronous): state = IDLE, req_d = snz_d = 0, all counters 0, so buzz = 0, ringing = 0, snooze_count = 0.
- After reset release with buzz_req already high and alarm_on high, the first edge sees req_rise and rings. This is intended: the alarm fires on power-up inside the alarm minute.
- Latency: req_rise sampled at edge n means state = RING and buzz = 1 during cycle n+1.
- Beep pattern: buzz is 1,0,1,0,… for RING_MAX cycles total. RING lasts exactly RING_MAX cycles before SILENCED.
- Snooze: snz_rise sampled at edge n means buzz = 0 from cycle n+1. SNOOZE lasts SNOOZE_LEN cycles, then RING restarts with buzz = 1.
- alarm_on falling at edge n means buzz = 0 and ringing = 0 in cycle n+1.
- snooze held high produces only one event. A new press requires a low sample first.
- A mid-operation rst returns to IDLE immediately. No event is remembered.

## Test plan
Run with RING_MAX=6, SNOOZE_LEN=4, MAX_SNOOZE=2.
- Basic ring: alarm_on=1, buzz_req 0→1 at edge 5, held for 20 cycles. Required: buzz = 1,0,1,0,1,0 in cycles 6–11, then SILENCED with buzz = 0. Return to IDLE one cycle after buzz_req drops. No retrigger while buzz_req stays high.
- Snooze: press snooze one cycle in RING cycle 2. Required: buzz = 0 for 4 cycles, ringing = 1, snooze_count = 1, then RING restarts with buzz = 1 and ring_ct = 0.
- Snooze limit: press 3 times in successive RING periods. Required: snooze_count stops at 2, the third press is ignored, and the ring times out to SILENCED after 6 cycles.
- Cancel: alarm_on → 0 during SNOOZE. Required: next cycle IDLE, ringing = 0, snooze_count = 0. A later buzz_req rise with alarm_on = 0 gives no ring.
- Priority: snz_rise coincides with ring_ct = 5. Required: go to SNOOZE, not SILENCED. Separately, alarm_on = 0 coinciding with req_rise stays in IDLE.
- Reset: assert rst asynchronously mid-RING, between clock edges. Required: buzz = 0, ringing = 0 immediately. Release rst with buzz_req = 1 and alarm_on = 1. Required: RING one cycle after the first edge.
